// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter sharing one single-port data memory between pipeline (P) and loader (L) ports
module data_mem_arbiter #(
  parameter longint unsigned ADDR_LIMIT = 64'd4095,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [63:0]       p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_done,
  output logic              p_err,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [63:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic              l_err,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [11:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [15:0]       err_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic rr, win, we_q, err_q, pick_l, acc, rsp;
  logic [11:0] addr_q;
  logic [63:0] sel_addr;
  logic [DATA_W-1:0] wdata_q, p_rdata_q, l_rdata_q, resp_data;
  assign pick_l = l_req & (~p_req | rr);
  assign sel_addr = pick_l ? l_addr : p_addr;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? ((p_req | l_req) ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    acc = state == ACCESS;
    rsp = state == RESP;
    busy = state != IDLE;
    p_gnt = acc & ~win;
    l_gnt = acc & win;
    mem_en = acc & ~err_q;
    mem_we = mem_en & we_q;
    mem_addr = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    resp_data = (~we_q & ~err_q) ? mem_rdata : '0;
    p_done = rsp & ~win;
    l_done = rsp & win;
    p_err = p_done & err_q;
    l_err = l_done & err_q;
    p_rdata = p_done ? resp_data : p_rdata_q;
    l_rdata = l_done ? resp_data : l_rdata_q;
  end
  // Read data is forwarded combinationally in the done cycle and captured for holding afterwards
  always_ff @(posedge clk)
    if (reset) begin
      rr <= 1'b0;
      win <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
      err_count <= '0;
    end else begin
      if (state == IDLE && (p_req | l_req)) begin
        win <= pick_l;
        we_q <= pick_l ? l_we : p_we;
        err_q <= sel_addr > ADDR_LIMIT;
        addr_q <= sel_addr[11:0];
        wdata_q <= pick_l ? l_wdata : p_wdata;
      end
      if (rsp) begin
        rr <= ~win;
        if (win) l_rdata_q <= resp_data;
        else p_rdata_q <= resp_data;
        if (err_q && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized scoreboard bench with a transaction-level reference model
module tb_data_mem_arbiter;
  logic clk = 0, reset;
  logic p_req, p_we, l_req, l_we;
  logic [63:0] p_addr, l_addr, p_wdata, l_wdata;
  logic p_gnt, p_done, p_err, l_gnt, l_done, l_err;
  logic [63:0] p_rdata, l_rdata;
  logic mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic busy;
  logic [15:0] err_count;
  int checks = 0, errors = 0;
  typedef struct {
    bit port;
    bit err;
    bit gap;
    logic mem_en;
    logic mem_we;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] rdata;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  bit [63:0] ref_mem[4096];
  bit [63:0] bmem[4096];
  bit bvld[4096];
  bit rr_model;
  logic [15:0] cnt_model;
  int cyc, gnt_cyc, done_cyc;
  logic [63:0] last_p, last_l;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_done(p_done), .p_err(p_err), .p_rdata(p_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_err(l_err), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input int a);
    return a == 10 ? 64'd11 : 64'(a) * 64'h9E3779B97F4A7C15 + 64'd1;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      bmem[mem_addr] <= mem_wdata;
      bvld[mem_addr] <= 1'b1;
    end
    if (mem_en) mem_rdata <= bvld[mem_addr] ? bmem[mem_addr] : init_val(int'(mem_addr));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic predict(input bit port, input bit we, input logic [63:0] addr, input logic [63:0] wd, input bit gap);
    exp_t e;
    e.port = port;
    e.err = addr > 64'd4095;
    e.gap = gap;
    e.mem_en = !e.err;
    e.mem_we = we && !e.err;
    e.mem_addr = e.err ? 12'd0 : addr[11:0];
    e.mem_wdata = e.err ? 64'd0 : wd;
    e.rdata = (we || e.err) ? 64'd0 : ref_mem[addr[11:0]];
    if (we && !e.err) ref_mem[addr[11:0]] = wd;
    e.cnt = cnt_model;
    if (e.err && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    rr_model = !port;
    q.push_back(e);
  endtask

  task automatic batch(input bit up, input bit ul, input bit pw, input bit lw,
                       input logic [63:0] pa, input logic [63:0] la, input logic [63:0] pd, input logic [63:0] ld);
    int n = 0;
    if (up && ul && rr_model) begin
      predict(1, lw, la, ld, 0);
      predict(0, pw, pa, pd, 0);
    end else begin
      if (up) predict(0, pw, pa, pd, 0);
      if (ul) predict(1, lw, la, ld, 0);
    end
    p_req = up; p_we = pw; p_addr = pa; p_wdata = pd;
    l_req = ul; l_we = lw; l_addr = la; l_wdata = ld;
    while ((p_req || l_req) && n < 40) begin
      @(negedge clk);
      n++;
      if (p_done) p_req = 0;
      if (l_done) l_req = 0;
    end
    chk("batch_complete", {p_req, l_req}, 0);
    p_req = 0;
    l_req = 0;
  endtask

  function automatic logic [63:0] rnd_addr();
    int r = $urandom_range(0, 9);
    return r == 0 ? {$urandom, $urandom} | 64'h1_0000_0000 : r == 1 ? 64'd4096 :
           r == 2 ? 64'd4095 : r == 3 ? 64'd0 : 64'($urandom_range(0, 4095));
  endfunction

  // Monitor: compares every grant and completion against the head of the expected queue
  initial begin
    exp_t e;
    cyc = 0; gnt_cyc = -10; done_cyc = -10; last_p = 0; last_l = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        q.delete();
        last_p = 0;
        last_l = 0;
        chk("rst_busy", busy, 0);
        chk("rst_mem", {mem_en, mem_we}, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_pulses", {p_gnt, l_gnt, p_done, l_done, p_err, l_err}, 0);
        chk("rst_p_rdata", p_rdata, 0);
        chk("rst_l_rdata", l_rdata, 0);
      end else begin
        if (!p_gnt && !l_gnt) chk("mem_idle", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        else if (q.size() == 0) chk("unexpected_gnt", {p_gnt, l_gnt}, 0);
        else begin
          e = q[0];
          chk("gnt_port", {p_gnt, l_gnt}, e.port ? 2'b01 : 2'b10);
          chk("gnt_busy", busy, 1);
          chk("mem_en", mem_en, e.mem_en);
          chk("mem_we", mem_we, e.mem_we);
          chk("mem_addr", mem_addr, e.mem_addr);
          chk("mem_wdata", mem_wdata, e.mem_wdata);
          gnt_cyc = cyc;
        end
        if (p_done || l_done) begin
          if (q.size() == 0) chk("unexpected_done", {p_done, l_done}, 0);
          else begin
            e = q.pop_front();
            chk("done_port", {p_done, l_done}, e.port ? 2'b01 : 2'b10);
            chk("done_latency", cyc - gnt_cyc, 1);
            chk("done_err", e.port ? l_err : p_err, e.err);
            chk("done_rdata", e.port ? l_rdata : p_rdata, e.rdata);
            chk("done_err_count", err_count, e.cnt);
            if (e.gap) chk("done_spacing", cyc - done_cyc, 3);
            done_cyc = cyc;
            if (e.port) last_l = e.rdata;
            else last_p = e.rdata;
          end
        end
        if (!p_done) begin
          chk("p_rdata_hold", p_rdata, last_p);
          chk("p_err_idle", p_err, 0);
        end
        if (!l_done) begin
          chk("l_rdata_hold", l_rdata, last_l);
          chk("l_err_idle", l_err, 0);
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    rr_model = 0;
    cnt_model = 0;
    reset = 1;
    p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    batch(0, 1, 0, 1, 0, 64'd4095, 0, 64'hDEAD);
    batch(1, 0, 0, 0, 64'd10, 0, 64'h55, 0);
    batch(1, 0, 0, 0, 64'd4096, 0, 0, 0);
    batch(0, 1, 0, 0, 0, 64'd4095, 0, 0);
    // Requests held continuously: expect alternating grants with 3-cycle spacing
    for (int i = 0; i < 4; i++) predict(rr_model, 0, rr_model ? 64'd30 : 64'd20, 0, i > 0);
    p_req = 1; p_we = 0; p_addr = 20; p_wdata = 0;
    l_req = 1; l_we = 0; l_addr = 30; l_wdata = 0;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (p_done || l_done) n++;
    end
    p_req = 0;
    l_req = 0;
    chk("hold_count", n, 4);
    for (int i = 0; i < 150; i++) begin
      int m = $urandom_range(0, 2);
      batch(m != 1, m != 0, 1'($urandom), 1'($urandom), rnd_addr(), rnd_addr(),
            {$urandom, $urandom}, {$urandom, $urandom});
    end
    // Abort an L write with reset mid-access, then confirm P wins the next dual request
    batch(1, 0, 0, 0, 64'd5, 0, 0, 0);
    predict(1, 1, 64'd100, 64'hCAFE, 0);
    l_req = 1; l_we = 1; l_addr = 100; l_wdata = 64'hCAFE;
    n = 0;
    while (!l_gnt && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_gnt_seen", l_gnt, 1);
    reset = 1;
    l_req = 0;
    @(negedge clk);
    reset = 0;
    rr_model = 0;
    cnt_model = 0;
    batch(1, 1, 0, 0, 64'd100, 64'd7, 0, 0);
    batch(1, 1, 1, 0, 64'd8, 64'd8, 64'h1234, 0);
    // Saturation: preload the counter near its ceiling instead of spending ~200k cycles
    @(negedge clk);
    dut.err_count = 16'hFFFD;
    cnt_model = 16'hFFFD;
    for (int i = 0; i < 4; i++) batch(1, 1, 0, 1, 64'd4096 + 64'(i), {$urandom, $urandom} | 64'h1_0000_0000, 0, 0);
    repeat (3) @(negedge clk);
    chk("sat_err_count", err_count, cnt_model);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
